// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
// Hazard controller for the 5-stage pipeline. It sits beside ID and drives
// the PC / IF/ID / ID/EX buffer controls directly. It handles three cases:
//   - load-use hazards against the load currently in EX,
//   - taken-branch redirects (the wrong-path fetch in IF/ID is squashed),
//   - structural hazards on the multi-cycle mult/div (HI/LO) unit.
// A stall freezes PC and IF/ID and injects a bubble into ID/EX.
// A stall always wins over a branch redirect. The stalled branch stays in ID
// and resolves again on the next cycle.
module pipeline_hazard_unit #(
    parameter int MULDIV_LAT  = 4,   // busy cycles after a mult/div issues (1..15)
    parameter int STALL_CNT_W = 32   // width of the saturating stall counter
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [4:0]             ID_rs,
    input  logic [4:0]             ID_rt,
    input  logic                   ID_usesRs,
    input  logic                   ID_usesRt,
    input  logic                   ID_isMulDiv,
    input  logic                   ID_readsHiLo,
    input  logic                   ID_BranchTaken,
    input  logic                   EX_MemRead,
    input  logic                   EX_RegWrite,
    input  logic [4:0]             EX_WriteReg,
    output logic                   PC_Write,
    output logic                   IF_ID_Write,
    output logic                   IF_ID_Flush,
    output logic                   ID_EX_Flush,
    output logic                   MulDiv_Busy,
    output logic                   Stall,
    output logic [STALL_CNT_W-1:0] Stall_Count
);

    typedef enum logic {
        RUN         = 1'b0,
        MULDIV_WAIT = 1'b1
    } state_t;

    localparam logic [3:0]             LAT_LOAD = 4'(MULDIV_LAT);
    localparam logic [STALL_CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [STALL_CNT_W-1:0] CNT_ONE  = STALL_CNT_W'(1);

    state_t     state;
    state_t     state_next;
    logic [3:0] busy_cnt;
    logic [3:0] busy_cnt_next;

    logic rs_match;
    logic rt_match;
    logic load_use;
    logic hilo_hazard;
    logic hazard;
    logic issue;

    // Hazard detection: combinational on the current ID/EX fields and the busy flag.
    always_comb begin
        rs_match    = ID_usesRs && (ID_rs == EX_WriteReg);
        rt_match    = ID_usesRt && (ID_rt == EX_WriteReg);
        // $zero is never written, so a load targeting r0 cannot create a dependency.
        load_use    = EX_MemRead && EX_RegWrite && (EX_WriteReg != 5'd0)
                      && (rs_match || rt_match);
        hilo_hazard = MulDiv_Busy && (ID_isMulDiv || ID_readsHiLo);
        hazard      = load_use || hilo_hazard;
        // A mult/div only leaves ID when nothing holds it there. The unit is
        // idle whenever this is true, because a busy unit forces hilo_hazard.
        issue       = ID_isMulDiv && !hazard;
    end

    // Mult/div sequencer: next-state and next-count logic.
    always_comb begin
        // NOTE: assigning every output a default first means no path leaves a
        // variable unassigned, so no latch is inferred.
        state_next    = state;
        busy_cnt_next = busy_cnt;
        case (state)
            RUN: begin
                if (issue) begin
                    busy_cnt_next = LAT_LOAD;
                    state_next    = MULDIV_WAIT;
                end
            end
            MULDIV_WAIT: begin
                // When the count reaches zero the unit falls idle. A waiting
                // mult/div issues on the next edge, not this one.
                if (busy_cnt <= 4'd1) begin
                    busy_cnt_next = 4'd0;
                    state_next    = RUN;
                end else begin
                    busy_cnt_next = busy_cnt - 4'd1;
                end
            end
            default: begin
                busy_cnt_next = 4'd0;
                state_next    = RUN;
            end
        endcase
    end

    // Mult/div state register with a registered busy flag.
    // A reset abandons any operation that is in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments. All flops then
        // sample pre-edge values, and the result does not depend on the order
        // in which the processes are evaluated.
        if (Reset) begin
            state       <= RUN;
            busy_cnt    <= 4'd0;
            MulDiv_Busy <= 1'b0;
        end else begin
            state       <= state_next;
            busy_cnt    <= busy_cnt_next;
            MulDiv_Busy <= (busy_cnt_next != 4'd0);
        end
    end

    // Buffer and PC controls.
    // While Reset is high, the buffers are held flushed and the PC is held.
    always_comb begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
        Stall       = 1'b0;
        if (!Reset) begin
            if (hazard) begin
                // Freeze IF and ID. Send a bubble down into EX.
                Stall       = 1'b1;
                IF_ID_Flush = 1'b0;
            end else begin
                PC_Write    = 1'b1;
                IF_ID_Write = 1'b1;
                ID_EX_Flush = 1'b0;
                IF_ID_Flush = ID_BranchTaken;
            end
        end
    end

    // Stall-cycle performance counter. It saturates at all-ones.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Stall_Count <= '0;
        end else if (Stall && (Stall_Count != CNT_MAX)) begin
            Stall_Count <= Stall_Count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit
// Self-checking bench for pipeline_hazard_unit. A behavioural model tracks
// the remaining mult/div busy cycles and the stall count as plain integers.
// One compare process checks both DUTs against that model on every negedge.
// The second DUT is a 4-bit-counter build and exercises saturation.
// A directed prologue pins the model with literal expectations.
// A randomized phase follows.
`timescale 1ns/1ps
module tb_pipeline_hazard_unit;

    localparam int LAT = 4;

    logic       Clk;
    logic       Reset;
    logic [4:0] ID_rs, ID_rt, EX_WriteReg;
    logic       ID_usesRs, ID_usesRt, ID_isMulDiv, ID_readsHiLo, ID_BranchTaken;
    logic       EX_MemRead, EX_RegWrite;

    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, busy, stall;
    logic [31:0] stall_count;
    logic        pc_write4, if_id_write4, if_id_flush4, id_ex_flush4, busy4, stall4;
    logic [3:0]  stall_count4;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_hazard_unit #(.MULDIV_LAT(LAT), .STALL_CNT_W(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_usesRs(ID_usesRs), .ID_usesRt(ID_usesRt),
        .ID_isMulDiv(ID_isMulDiv), .ID_readsHiLo(ID_readsHiLo),
        .ID_BranchTaken(ID_BranchTaken),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
        .PC_Write(pc_write), .IF_ID_Write(if_id_write), .IF_ID_Flush(if_id_flush),
        .ID_EX_Flush(id_ex_flush), .MulDiv_Busy(busy), .Stall(stall),
        .Stall_Count(stall_count)
    );

    pipeline_hazard_unit #(.MULDIV_LAT(LAT), .STALL_CNT_W(4)) dut4 (
        .Clk(Clk), .Reset(Reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_usesRs(ID_usesRs), .ID_usesRt(ID_usesRt),
        .ID_isMulDiv(ID_isMulDiv), .ID_readsHiLo(ID_readsHiLo),
        .ID_BranchTaken(ID_BranchTaken),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
        .PC_Write(pc_write4), .IF_ID_Write(if_id_write4), .IF_ID_Flush(if_id_flush4),
        .ID_EX_Flush(id_ex_flush4), .MulDiv_Busy(busy4), .Stall(stall4),
        .Stall_Count(stall_count4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int     m_busy_left;   // cycles the unit stays occupied
    longint m_stalls;      // stalled cycles since reset (unbounded)

    function automatic bit model_stall();
        bit dep;
        dep = EX_MemRead && EX_RegWrite && (EX_WriteReg != 0) &&
              ((ID_usesRs && ID_rs == EX_WriteReg) || (ID_usesRt && ID_rt == EX_WriteReg));
        return !Reset && (dep || (m_busy_left > 0 && (ID_isMulDiv || ID_readsHiLo)));
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_busy_left = 0;
            m_stalls    = 0;
        end else begin
            bit s;
            s = model_stall();
            if (s) m_stalls++;
            if (m_busy_left > 0) m_busy_left--;
            else if (ID_isMulDiv && !s) m_busy_left = LAT;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge Clk) begin
        bit     es;
        longint sat4;
        es   = model_stall();
        sat4 = (m_stalls > 15) ? 15 : m_stalls;
        check("stall",        stall,        es);
        check("pc_write",     pc_write,     !Reset && !es);
        check("if_id_write",  if_id_write,  !Reset && !es);
        check("if_id_flush",  if_id_flush,  Reset || (!es && ID_BranchTaken));
        check("id_ex_flush",  id_ex_flush,  Reset || es);
        check("busy",         busy,         m_busy_left > 0);
        check("stall_count",  stall_count,  m_stalls);
        check("stall4",       stall4,       es);
        check("pc_write4",    pc_write4,    !Reset && !es);
        check("if_id_write4", if_id_write4, !Reset && !es);
        check("if_id_flush4", if_id_flush4, Reset || (!es && ID_BranchTaken));
        check("id_ex_flush4", id_ex_flush4, Reset || es);
        check("busy4",        busy4,        m_busy_left > 0);
        check("stall_count4", stall_count4, sat4);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic probe();
        @(negedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        ID_rs = 0; ID_rt = 0; ID_usesRs = 0; ID_usesRt = 0;
        ID_isMulDiv = 0; ID_readsHiLo = 0; ID_BranchTaken = 0;
        EX_MemRead = 0; EX_RegWrite = 0; EX_WriteReg = 0;
    endtask

    task automatic set_load_use();
        EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 5'd8;
        ID_usesRt = 1; ID_rt = 5'd8;
    endtask

    initial begin
        Reset = 1'b0;
        clear_inputs();
        #1 Reset = 1'b1;
        #2;
        check("rst_pc_write",    pc_write,    0);
        check("rst_if_id_flush", if_id_flush, 1);
        check("rst_id_ex_flush", id_ex_flush, 1);
        tick(); tick();
        Reset = 1'b0;

        // Idle after reset release.
        probe();
        check("idle_pc_write",    pc_write,    1);
        check("idle_if_id_write", if_id_write, 1);
        check("idle_if_id_flush", if_id_flush, 0);
        check("idle_id_ex_flush", id_ex_flush, 0);
        check("idle_busy",        busy,        0);
        check("idle_count",       stall_count, 0);

        // Load-use against r8.
        tick(); set_load_use();
        probe();
        check("lu_stall",       stall,       1);
        check("lu_pc_write",    pc_write,    0);
        check("lu_if_id_write", if_id_write, 0);
        check("lu_id_ex_flush", id_ex_flush, 1);
        tick(); clear_inputs();
        probe();
        check("lu_count", stall_count, 1);

        // A load into r0 never stalls.
        tick(); set_load_use(); EX_WriteReg = 0; ID_rt = 0;
        probe();
        check("r0_stall", stall, 0);

        // Taken branch, with no hazard and then with a load-use hazard.
        tick(); clear_inputs(); ID_BranchTaken = 1;
        probe();
        check("br_if_id_flush", if_id_flush, 1);
        check("br_pc_write",    pc_write,    1);
        tick(); set_load_use();
        probe();
        check("brlu_if_id_flush", if_id_flush, 0);
        check("brlu_stall",       stall,       1);
        tick(); clear_inputs();

        // Mult issues at E0, then mflo waits out the busy window.
        ID_isMulDiv = 1;
        probe();
        check("mul_issue_stall", stall, 0);
        tick(); ID_isMulDiv = 0; ID_readsHiLo = 1;
        for (int i = 0; i < LAT; i++) begin
            probe();
            check("mflo_busy",  busy,  1);
            check("mflo_stall", stall, 1);
            tick();
        end
        probe();
        check("mflo_go_busy",  busy,        0);
        check("mflo_go_stall", stall,       0);
        check("mflo_go_pc",    pc_write,    1);
        check("mflo_count",    stall_count, 6);
        tick(); clear_inputs();

        // Back-to-back divides: the second one waits LAT cycles in ID.
        ID_isMulDiv = 1;
        probe();
        check("div1_stall", stall, 0);
        tick();
        for (int i = 0; i < LAT; i++) begin
            probe();
            check("div2_wait_busy",  busy,  1);
            check("div2_wait_stall", stall, 1);
            tick();
        end
        probe();
        check("div2_free_busy",  busy,  0);
        check("div2_free_stall", stall, 0);
        tick();
        probe();
        check("div2_issued_busy", busy,        1);
        check("div2_count",       stall_count, 10);
        tick(); clear_inputs();
        for (int i = 0; i < LAT + 1; i++) tick();

        // Reset mid-operation, at busy_cnt == 2.
        ID_isMulDiv = 1;
        tick(); clear_inputs();
        tick(); tick();
        #1 Reset = 1'b1;
        #1;
        check("mid_rst_busy",  busy,        0);
        check("mid_rst_pc",    pc_write,    0);
        check("mid_rst_flush", id_ex_flush, 1);
        check("mid_rst_count", stall_count, 0);
        #3 Reset = 1'b0;
        ID_readsHiLo = 1;
        probe();
        check("post_rst_stall", stall, 0);
        check("post_rst_busy",  busy,  0);
        tick();
        probe();
        check("post_rst_stall2", stall, 0);
        tick(); clear_inputs();

        // Saturation of the 4-bit counter over 20 stalled cycles.
        set_load_use();
        for (int i = 0; i < 20; i++) tick();
        probe();
        check("sat_count32", stall_count,  20);
        check("sat_count4",  stall_count4, 15);
        tick(); clear_inputs();

        // Randomized phase.
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (Reset) Reset = 1'b0;
            else if ($urandom_range(0, 199) == 0) Reset = 1'b1;
            ID_rs          = 5'($urandom_range(0, 3));
            ID_rt          = 5'($urandom_range(0, 3));
            EX_WriteReg    = 5'($urandom_range(0, 3));
            ID_usesRs      = 1'($urandom_range(0, 1));
            ID_usesRt      = 1'($urandom_range(0, 1));
            EX_MemRead     = 1'($urandom_range(0, 2) == 0);
            EX_RegWrite    = 1'($urandom_range(0, 3) != 0);
            ID_isMulDiv    = 1'($urandom_range(0, 3) == 0);
            ID_readsHiLo   = 1'($urandom_range(0, 3) == 0);
            ID_BranchTaken = 1'($urandom_range(0, 3) == 0);
        end
        tick(); clear_inputs(); Reset = 1'b0;
        probe();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
Central hazard controller for the 5-stage pipeline. It sequences the IF/ID and ID/EX pipeline buffers and the PC through write-enable, flush and bubble controls. It detects three conditions: load-use hazards, taken-branch redirects, and structural hazards on the multi-cycle mult/div (HI/LO) unit. It sits beside the ID stage and drives the buffer controls directly.

Parameters:
MULDIV_LAT, 4, cycles the mult/div unit stays busy after issue; legal range 1..15
STALL_CNT_W, 32, width of the saturating stall-cycle performance counter

Ports:
Clk  input  1  pipeline clock; all state updates on posedge
Reset  input  1  asynchronous, active-high reset
ID_rs  input  5  rs field of the instruction in ID
ID_rt  input  5  rt field of the instruction in ID
ID_usesRs  input  1  ID instruction reads rs
ID_usesRt  input  1  ID instruction reads rt
ID_isMulDiv  input  1  ID instruction is mult/multu/div/divu
ID_readsHiLo  input  1  ID instruction is mfhi/mflo
ID_BranchTaken  input  1  branch/jump resolved taken in ID
EX_MemRead  input  1  instruction in EX is a load
EX_RegWrite  input  1  instruction in EX writes the register file
EX_WriteReg  input  5  destination register of the EX instruction
PC_Write  output  1  PC load enable
IF_ID_Write  output  1  IF/ID buffer load enable
IF_ID_Flush  output  1  IF/ID buffer loads a NOP (instruction 0, controls 0)
ID_EX_Flush  output  1  ID/EX buffer loads a bubble (all controls 0)
MulDiv_Busy  output  1  mult/div unit occupied
Stall  output  1  pipeline stalled this cycle
Stall_Count  output  STALL_CNT_W  number of stalled cycles since reset

Behaviour:
- State machine: RUN, MULDIV_WAIT. There is a 4-bit busy counter, busy_cnt.
- Reset asserted, asynchronously and at any time:
  - state=RUN, busy_cnt=0, MulDiv_Busy=0, Stall_Count=0.
  - While Reset is high: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, Stall=0.
  - A reset during MULDIV_WAIT abandons the count; the first cycle after release is RUN with Busy=0.
- MulDiv_Busy = (busy_cnt != 0). It is registered.
- load_use = EX_MemRead & EX_RegWrite & (EX_WriteReg != 0) & ((ID_usesRs & ID_rs==EX_WriteReg) | (ID_usesRt & ID_rt==EX_WriteReg)).
- hilo_hazard = MulDiv_Busy & (ID_isMulDiv | ID_readsHiLo).
- Stall = load_use | hilo_hazard. This is combinational on the current inputs and state, with zero-cycle latency.
- Stall=1 gives: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0.
- Stall=0 gives: PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0, IF_ID_Flush=ID_BranchTaken.
- Stall has priority over branch. ID_BranchTaken is ignored while Stall=1, because the branch stays in ID and re-resolves next cycle.
- Issue: a mult/div issues when ID_isMulDiv=1 and Stall=0 at a posedge. On that edge busy_cnt loads MULDIV_LAT and state moves to MULDIV_WAIT.
- MULDIV_WAIT:
  - busy_cnt decrements each posedge.
  - When busy_cnt is 1 at a posedge, it goes to 0 and state returns to RUN.
  - Busy is therefore high for exactly MULDIV_LAT cycles after the issue edge.
  - A mult/div or mfhi/mflo arriving during that window stalls until Busy falls, then issues or proceeds in the first Busy=0 cycle.
- Back-to-back issue:
  - A new mult/div can issue only in a cycle with Busy=0, and never on the same edge busy_cnt reaches 0.
  - So there is a minimum spacing of MULDIV_LAT+1 cycles between issue edges.
- load_use and hilo_hazard may be true together. The result is a single stall; the cycle counts once.
- Stall_Count increments on each posedge where Stall=1 and Reset=0. It saturates at all-ones and does not wrap.
- An EX_WriteReg of 0 never causes a stall, because $zero is never written.

Test Plan:
- Reset:
  - Stimulus: assert Reset mid-cycle, all inputs 0.
  - Required: immediately PC_Write=0, IF_ID_Flush=1, ID_EX_Flush=1.
  - After release with no hazard: PC_Write=1, IF_ID_Write=1, both flushes 0, Busy=0, Stall_Count=0.
- Load-use:
  - Stimulus: EX_MemRead=1, EX_RegWrite=1, EX_WriteReg=8, ID_usesRt=1, ID_rt=8 for one cycle.
  - Required: Stall=1, PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, and Stall_Count goes to 1.
  - Repeat with EX_WriteReg=0 and ID_rt=0: required Stall=0.
- Branch:
  - Stimulus: ID_BranchTaken=1, no hazard.
  - Required: IF_ID_Flush=1, PC_Write=1.
  - Repeat with the load-use condition also true: required IF_ID_Flush=0, Stall=1.
- Mult/div latency (MULDIV_LAT=4):
  - Stimulus: issue mult at edge E0.
  - Required: Busy=1 for the 4 cycles after E0 and 0 after edge E4.
  - Stimulus: mflo in ID on each of those cycles.
  - Required: 4 stall cycles and Stall_Count=4; mflo proceeds in the cycle after E4.
- Back-to-back div:
  - Stimulus: div issued, a second div held in ID.
  - Required: the second div stalls for 4 cycles and issues on the edge after Busy falls; Busy then rises again for 4 cycles.
- Reset mid-operation:
  - Stimulus: Reset pulse at busy_cnt=2.
  - Required: Busy=0 and state=RUN immediately, with no further stalls from the abandoned operation.
  - Also: force Stall_Count to all-ones (STALL_CNT_W=4 build) and stall again; required: it stays at 0xF.
